// File: rtl/vga_pkg.sv
// Shared types, timing-mode constants and helpers for the VGA/DVI pixel output stage.
package vga_pkg;

  // Output stage operating states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // 1280x720 @ 60 Hz (74.25 MHz pixel clock), positive syncs.
  localparam int MODE720_H_SW  = 40;
  localparam int MODE720_H_BP  = 220;
  localparam int MODE720_H_ACT = 1280;
  localparam int MODE720_H_FP  = 110;
  localparam int MODE720_V_SW  = 5;
  localparam int MODE720_V_BP  = 20;
  localparam int MODE720_V_ACT = 720;
  localparam int MODE720_V_FP  = 5;
  localparam bit MODE720_HS_POL = 1'b1;
  localparam bit MODE720_VS_POL = 1'b1;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs.
  localparam int MODE480_H_SW  = 96;
  localparam int MODE480_H_BP  = 48;
  localparam int MODE480_H_ACT = 640;
  localparam int MODE480_H_FP  = 16;
  localparam int MODE480_V_SW  = 2;
  localparam int MODE480_V_BP  = 33;
  localparam int MODE480_V_ACT = 480;
  localparam int MODE480_V_FP  = 10;
  localparam bit MODE480_HS_POL = 1'b0;
  localparam bit MODE480_VS_POL = 1'b0;

  // Clocks per line.
  function automatic int h_total(input int sw, input int bp, input int act, input int fp);
    return sw + bp + act + fp;
  endfunction

  // Lines per frame.
  function automatic int v_total(input int sw, input int bp, input int act, input int fp);
    return sw + bp + act + fp;
  endfunction

endpackage

// File: rtl/vga_stream_out_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on dout whenever not empty.
module sync_fifo_fwft #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_wr;
  logic          do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wptr - rptr;
  assign empty = (level == '0);
  assign full  = level[AW];
  assign dout  = mem[rptr[AW-1:0]];
  assign do_wr = wr & ~full & ~flush;
  assign do_rd = rd & ~empty & ~flush;

  // Storage array; no reset needed since the pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= din;
  end

  // Pointer update; flush empties the FIFO and overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/vga_stream_out.sv
// VGA/DVI pixel output stage: raster timing, pixel FIFO, upstream throttling and error flags.
module vga_stream_out
  import vga_pkg::*;
#(
  parameter int             DW      = 16,
  parameter int             H_SW    = MODE720_H_SW,
  parameter int             H_BP    = MODE720_H_BP,
  parameter int             H_ACT   = MODE720_H_ACT,
  parameter int             H_FP    = MODE720_H_FP,
  parameter int             V_SW    = MODE720_V_SW,
  parameter int             V_BP    = MODE720_V_BP,
  parameter int             V_ACT   = MODE720_V_ACT,
  parameter int             V_FP    = MODE720_V_FP,
  parameter bit             HS_POL  = MODE720_HS_POL,
  parameter bit             VS_POL  = MODE720_VS_POL,
  parameter int             FIFO_AW = 4,
  parameter int             LOW_WM  = 4,
  parameter int             HIGH_WM = 12,
  parameter logic [DW-1:0]  BLANK   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [DW-1:0]      din,
  input  logic               din_vld,
  output logic               rdy,
  output logic [DW-1:0]      vga_rgb,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_de,
  output logic               frame_start,
  output logic               underflow,
  output logic               overflow,
  input  logic               err_clr,
  output logic [FIFO_AW:0]   level
);

  localparam int H_TOT = h_total(H_SW, H_BP, H_ACT, H_FP);
  localparam int V_TOT = v_total(V_SW, V_BP, V_ACT, V_FP);
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam int H_ACT_LO = H_SW + H_BP;
  localparam int H_ACT_HI = H_SW + H_BP + H_ACT;
  localparam int V_ACT_LO = V_SW + V_BP;
  localparam int V_ACT_HI = V_SW + V_BP + V_ACT;

  logic [HW-1:0] cnt_h;
  logic [VW-1:0] cnt_v;
  state_t        state;
  state_t        state_next;
  logic          h_wrap;
  logic          frame_end;
  logic          hs_c;
  logic          vs_c;
  logic          act_c;
  logic          run;
  logic          fifo_rd;
  logic          fifo_wr;
  logic          fifo_flush;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW-1:0] fifo_dout;
  logic          rdy_next;

  assign h_wrap    = (cnt_h == H_LAST);
  assign frame_end = h_wrap & (cnt_v == V_LAST);
  assign hs_c      = int'(cnt_h) < H_SW;
  assign vs_c      = int'(cnt_v) < V_SW;
  assign act_c     = (int'(cnt_h) >= H_ACT_LO) && (int'(cnt_h) < H_ACT_HI) &&
                     (int'(cnt_v) >= V_ACT_LO) && (int'(cnt_v) < V_ACT_HI);
  assign run        = (state == RUN);
  assign fifo_rd    = act_c & run & ~fifo_empty;
  assign fifo_wr    = din_vld & ~fifo_full;
  assign fifo_flush = (state == IDLE);

  sync_fifo_fwft #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .wr    (fifo_wr),
    .din   (din),
    .rd    (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  // Free-running raster counters, independent of the operating state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (h_wrap) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
    end else begin
      cnt_h <= cnt_h + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: leaving IDLE is immediate, everything else waits for the frame edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = FILL;
      FILL: begin
        if (frame_end) begin
          if (!en)                                       state_next = IDLE;
          else if (int'(level) >= HIGH_WM || fifo_full)  state_next = RUN;
        end
      end
      RUN:  if (frame_end && !en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Watermark hysteresis for the upstream ready, held low whenever IDLE is next.
  always_comb begin
    rdy_next = rdy;
    if (state_next == IDLE)           rdy_next = 1'b0;
    else if (int'(level) <= LOW_WM)   rdy_next = 1'b1;
    else if (int'(level) >= HIGH_WM)  rdy_next = 1'b0;
  end

  // One-cycle output pipeline plus sticky error flags (a set beats a clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync   <= ~HS_POL;
      vga_vsync   <= ~VS_POL;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      rdy         <= 1'b0;
    end else begin
      vga_hsync   <= hs_c ? HS_POL : ~HS_POL;
      vga_vsync   <= vs_c ? VS_POL : ~VS_POL;
      vga_de      <= act_c & run;
      vga_rgb     <= fifo_rd ? fifo_dout : BLANK;
      frame_start <= (cnt_h == '0) && (cnt_v == '0);
      underflow   <= (act_c & run & fifo_empty) | (underflow & ~err_clr);
      overflow    <= (din_vld & fifo_full) | (overflow & ~err_clr);
      rdy         <= rdy_next;
    end
  end

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed self-checking bench for vga_stream_out in a small 14x7 raster mode.
module tb_vga_stream_out;

  localparam int DW = 8;
  localparam logic [7:0] BLANK = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] din = 8'd0;
  logic       din_vld = 1'b0;
  logic       err_clr = 1'b0;
  logic       rdy;
  logic [7:0] vga_rgb;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_de;
  logic       frame_start;
  logic       underflow;
  logic       overflow;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;
  int cyc = -1;
  bit feed = 1'b1;

  vga_stream_out #(
    .DW(DW), .H_SW(2), .H_BP(2), .H_ACT(8), .H_FP(2),
    .V_SW(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FIFO_AW(4), .LOW_WM(4), .HIGH_WM(12),
    .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_vld(din_vld),
    .rdy(rdy), .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .frame_start(frame_start), .underflow(underflow),
    .overflow(overflow), .err_clr(err_clr), .level(level)
  );

  always #5 clk = ~clk;

  // Advance one clock; cyc then names the counter index whose decode is on the outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (feed) begin
      if (din_vld) din = din + 8'd1;
      din_vld = rdy;
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    cyc = -1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({vga_hsync, vga_vsync, vga_de, vga_rgb, rdy, level, frame_start, underflow, overflow} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got hs=%b vs=%b de=%b rgb=%h rdy=%b lvl=%0d fs=%b uf=%b of=%b want all 0",
               vga_hsync, vga_vsync, vga_de, vga_rgb, rdy, level, frame_start, underflow, overflow);
    end
    release_reset();
  endtask

  task automatic test_fill_hysteresis();
    tick();
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL first_frame_start got %b want 1", frame_start); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL fill_rdy_rise got %b want 1", rdy); end
    run_to(12);
    checks++;
    if (level !== 5'd12 || rdy !== 1'b1) begin
      errors++; $display("[TB] FAIL hyst_at_12 got level=%0d rdy=%b want level=12 rdy=1", level, rdy);
    end
    tick();
    checks++;
    if (level !== 5'd13 || rdy !== 1'b0) begin
      errors++; $display("[TB] FAIL hyst_fall got level=%0d rdy=%b want level=13 rdy=0", level, rdy);
    end
  endtask

  task automatic test_raster();
    logic [7:0] exp_pix;
    int de_count;
    exp_pix = 8'd0;
    de_count = 0;
    while (cyc < 195) begin
      int col, row;
      logic de_e, hs_e, vs_e, fs_e;
      logic [7:0] rgb_e;
      tick();
      col = cyc % 14;
      row = (cyc % 98) / 14;
      de_e = (cyc >= 98) && col >= 4 && col < 12 && row >= 2 && row < 6;
      hs_e = (col < 2);
      vs_e = (row < 1);
      fs_e = (cyc % 98 == 0);
      rgb_e = de_e ? exp_pix : BLANK;
      checks++;
      if (vga_de !== de_e) begin errors++; $display("[TB] FAIL raster_de cyc=%0d got %b want %b", cyc, vga_de, de_e); end
      checks++;
      if (vga_rgb !== rgb_e) begin errors++; $display("[TB] FAIL raster_rgb cyc=%0d got %h want %h", cyc, vga_rgb, rgb_e); end
      checks++;
      if (vga_hsync !== hs_e) begin errors++; $display("[TB] FAIL raster_hsync cyc=%0d got %b want %b", cyc, vga_hsync, hs_e); end
      checks++;
      if (vga_vsync !== vs_e) begin errors++; $display("[TB] FAIL raster_vsync cyc=%0d got %b want %b", cyc, vga_vsync, vs_e); end
      checks++;
      if (frame_start !== fs_e) begin errors++; $display("[TB] FAIL raster_fs cyc=%0d got %b want %b", cyc, frame_start, fs_e); end
      if (de_e) exp_pix = exp_pix + 8'd1;
      if (cyc >= 98 && vga_de === 1'b1) de_count++;
    end
    checks++;
    if (de_count != 32) begin errors++; $display("[TB] FAIL raster_de_count got %0d want 32", de_count); end
  endtask

  task automatic test_underflow();
    feed = 1'b0;
    din_vld = 1'b0;
    run_to(232);
    checks++;
    if (vga_de !== 1'b1 || vga_rgb !== 8'd36 || underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL uf_last_pixel got de=%b rgb=%h uf=%b want de=1 rgb=24 uf=0", vga_de, vga_rgb, underflow);
    end
    tick();
    checks++;
    if (vga_de !== 1'b1 || vga_rgb !== BLANK || underflow !== 1'b1) begin
      errors++; $display("[TB] FAIL uf_blank got de=%b rgb=%h uf=%b want de=1 rgb=a5 uf=1", vga_de, vga_rgb, underflow);
    end
    err_clr = 1'b1;
    tick();
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_set_wins got %b want 1", underflow); end
    run_to(236);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_clear got %b want 0", underflow); end
    err_clr = 1'b0;
    feed = 1'b1;
    din_vld = rdy;
  endtask

  task automatic test_en_drop();
    run_to(240);
    en = 1'b0;
    run_to(270);
    checks++;
    if (vga_de !== 1'b1) begin errors++; $display("[TB] FAIL en_drop_frame_completes got de=%b want 1", vga_de); end
    run_to(300);
    checks++;
    if (rdy !== 1'b0 || level !== 5'd0 || vga_de !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_state got rdy=%b level=%0d de=%b want 0 0 0", rdy, level, vga_de);
    end
    run_to(326);
    checks++;
    if (vga_de !== 1'b0 || vga_rgb !== BLANK) begin
      errors++; $display("[TB] FAIL idle_active got de=%b rgb=%h want de=0 rgb=a5", vga_de, vga_rgb);
    end
    run_to(330);
    en = 1'b1;
    run_to(343);
    checks++;
    if (level !== 5'd12 || rdy !== 1'b1) begin
      errors++; $display("[TB] FAIL refill_12 got level=%0d rdy=%b want 12 1", level, rdy);
    end
    tick();
    checks++;
    if (level !== 5'd13 || rdy !== 1'b0) begin
      errors++; $display("[TB] FAIL refill_13 got level=%0d rdy=%b want 13 0", level, rdy);
    end
    feed = 1'b0;
    din_vld = 1'b0;
    run_to(354);
    checks++;
    if (vga_de !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_de got %b want 0", vga_de); end
    run_to(424);
    checks++;
    if (vga_de !== 1'b1) begin errors++; $display("[TB] FAIL rerun_de got %b want 1", vga_de); end
  endtask

  task automatic test_pop_hysteresis();
    run_to(438);
    checks++;
    if (level !== 5'd4 || rdy !== 1'b0) begin
      errors++; $display("[TB] FAIL pop_at_4 got level=%0d rdy=%b want 4 0", level, rdy);
    end
    tick();
    checks++;
    if (level !== 5'd3 || rdy !== 1'b1) begin
      errors++; $display("[TB] FAIL pop_rise got level=%0d rdy=%b want 3 1", level, rdy);
    end
  endtask

  task automatic test_async_reset();
    run_to(442);
    checks++;
    if (vga_de !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_de got %b want 1", vga_de); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vga_hsync, vga_vsync, vga_de, vga_rgb, rdy, level, frame_start, underflow, overflow} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got hs=%b vs=%b de=%b rgb=%h rdy=%b lvl=%0d fs=%b uf=%b of=%b want all 0",
               vga_hsync, vga_vsync, vga_de, vga_rgb, rdy, level, frame_start, underflow, overflow);
    end
    release_reset();
    tick();
    checks++;
    if (frame_start !== 1'b1 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || level !== 5'd0) begin
      errors++; $display("[TB] FAIL restart got fs=%b hs=%b vs=%b level=%0d want 1 1 1 0", frame_start, vga_hsync, vga_vsync, level);
    end
  endtask

  task automatic test_overflow();
    din_vld = 1'b1;
    run_to(16);
    checks++;
    if (level !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_full got level=%0d of=%b want 16 0", level, overflow);
    end
    tick();
    din_vld = 1'b0;
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || rdy !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_set got level=%0d of=%b rdy=%b want 16 1 0", level, overflow, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_fill_hysteresis();
    test_raster();
    test_underflow();
    test_en_drop();
    test_pop_hysteresis();
    test_async_reset();
    feed = 1'b0;
    din_vld = 1'b0;
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
